sl3_lock_monitor: RTL and testbench

Link lock supervisor for the SL3 receive path. Watches per-word framing status from the word aligner, issues realignment requests, and owns the post-realign grace window during which framing errors are ignored. Declares lock after a run of clean words. Drops lock and requests a new realignment when errors inside a sliding window reach a threshold.

---
 rtl/sl3_lock_monitor.sv | 146 ++++++++++++++
 tb/tb_sl3_lock_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sl3_lock_monitor.sv
// rtl/sl3_lock_monitor.sv - SL3 receive link lock supervisor: relock, grace window, lock acquire, windowed error watch.
// SL3_LOCK_MON_STATS_EN exposes win_errs and relock_count; otherwise both read 0.
module sl3_lock_monitor #(
  parameter int TARGET_CHIP  = 2,
  parameter int GRACE_CYCLES = 64,
  parameter int GOOD_WORDS   = 64,
  parameter int ACQ_TIMEOUT  = 4096,
  parameter int WIN_LOG2     = 8,
  parameter int ERR_THRESH   = 16
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        din_valid,
  input  logic        frame_ok,
  input  logic        frame_err,
  output logic        relock_req,
  output logic        grace,
  output logic        locked,
  output logic [7:0]  win_errs,
  output logic [15:0] relock_count
);

  localparam int GW = $clog2(GRACE_CYCLES);
  localparam int CW = $clog2(GOOD_WORDS + 1);
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);
  localparam int EW = WIN_LOG2 + 1;

  typedef enum logic [3:0] {
    S_RELOCK = 4'b0001,
    S_GRACE  = 4'b0010,
    S_ACQ    = 4'b0100,
    S_LOCKED = 4'b1000
  } state_t;

  if (TARGET_CHIP < 0) begin : g_chip_sel_unused
  end

  state_t              state_q, state_d;
  logic                rst_q;
  logic [GW-1:0]       grace_cnt_q, grace_cnt_d;
  logic [CW-1:0]       good_q, good_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [EW-1:0]       errs_q, errs_d;
  logic                relock_req_q, grace_q, locked_q;
  logic                v_err, v_good;

  always_comb begin
    v_err       = din_valid & frame_err;
    v_good      = din_valid & frame_ok & ~frame_err;
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    good_d      = good_q;
    tmo_d       = tmo_q;
    win_d       = win_q;
    errs_d      = errs_q;
    // rst_q holds RELOCK for the first post-reset cycle so the request pulse is visible
    if (rst_q) begin
      state_d = S_RELOCK;
    end else begin
      case (state_q)
        S_RELOCK: begin
          state_d     = S_GRACE;
          grace_cnt_d = GW'(GRACE_CYCLES - 1);
          good_d      = '0;
          tmo_d       = '0;
          win_d       = '0;
          errs_d      = '0;
        end
        S_GRACE: begin
          if (grace_cnt_q == '0) state_d = S_ACQ;
          else grace_cnt_d = grace_cnt_q - GW'(1);
        end
        S_ACQ: begin
          tmo_d = tmo_q + TW'(1);
          if (v_err) good_d = '0;
          else if (v_good) good_d = good_q + CW'(1);
          if (good_d == CW'(GOOD_WORDS)) state_d = S_LOCKED;
          else if (tmo_q == TW'(ACQ_TIMEOUT - 1)) state_d = S_RELOCK;
        end
        S_LOCKED: begin
          if (din_valid) begin
            win_d = win_q + WIN_LOG2'(1);
            // an error on the wrap word opens the new window with a count of one
            if (win_q == '1) errs_d = EW'(v_err);
            else errs_d = errs_q + EW'(v_err);
          end
          if (v_err && errs_d >= EW'(ERR_THRESH)) state_d = S_RELOCK;
        end
        default: state_d = S_RELOCK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= S_RELOCK;
      rst_q        <= 1'b1;
      grace_cnt_q  <= '0;
      good_q       <= '0;
      tmo_q        <= '0;
      win_q        <= '0;
      errs_q       <= '0;
      relock_req_q <= 1'b0;
      grace_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_q        <= 1'b0;
      grace_cnt_q  <= grace_cnt_d;
      good_q       <= good_d;
      tmo_q        <= tmo_d;
      win_q        <= win_d;
      errs_q       <= errs_d;
      relock_req_q <= (state_d == S_RELOCK);
      grace_q      <= (state_d == S_GRACE);
      locked_q     <= (state_d == S_LOCKED);
    end
  end

  assign relock_req = relock_req_q;
  assign grace      = grace_q;
  assign locked     = locked_q;

`ifdef SL3_LOCK_MON_STATS_EN
  logic [15:0] relock_cnt_q, relock_cnt_d;

  always_comb begin
    relock_cnt_d = relock_cnt_q;
    if (state_q == S_RELOCK && !rst_q && relock_cnt_q != 16'hFFFF)
      relock_cnt_d = relock_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (srst) relock_cnt_q <= '0;
    else relock_cnt_q <= relock_cnt_d;
  end

  assign relock_count = relock_cnt_q;
  assign win_errs     = (32'(errs_q) > 32'd255) ? 8'hFF : 8'(errs_q);
`else
  assign relock_count = '0;
  assign win_errs     = '0;
`endif

endmodule

// File: tb/tb_sl3_lock_monitor.sv
// tb/tb_sl3_lock_monitor.sv - self-checking bench for sl3_lock_monitor with default parameters.
`timescale 1ns/1ps
module tb_sl3_lock_monitor;

  localparam int GRACE  = 64;
  localparam int GOOD   = 64;
  localparam int ACQ_TO = 4096;

`ifdef SL3_LOCK_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst, din_valid, frame_ok, frame_err;
  logic        relock_req, grace, locked;
  logic [7:0]  win_errs;
  logic [15:0] relock_count;

  int n_checks = 0;
  int n_pass   = 0;
  int stray    = 0;
  int grace_len;

  always #5 clk = ~clk;

  sl3_lock_monitor #(
    .TARGET_CHIP(2), .GRACE_CYCLES(GRACE), .GOOD_WORDS(GOOD),
    .ACQ_TIMEOUT(ACQ_TO), .WIN_LOG2(8), .ERR_THRESH(16)
  ) dut (
    .clk(clk), .srst(srst), .din_valid(din_valid), .frame_ok(frame_ok),
    .frame_err(frame_err), .relock_req(relock_req), .grace(grace),
    .locked(locked), .win_errs(win_errs), .relock_count(relock_count)
  );

  typedef struct {
    logic       rr, gr, lk;
    logic [7:0] we;
    string      tag;
  } exp_t;

  typedef struct {
    int         cnt;
    logic       v, ok, err;
    logic       rr, gr, lk;
    logic [7:0] we;
    string      tag;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input logic v, input logic ok, input logic err);
    din_valid = v;
    frame_ok  = ok;
    frame_err = err;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".relock_req"}, 32'(relock_req), 32'(e.rr));
      chk({e.tag, ".grace"},      32'(grace),      32'(e.gr));
      chk({e.tag, ".locked"},     32'(locked),     32'(e.lk));
      chk({e.tag, ".win_errs"},   32'(win_errs),   32'(e.we));
    end
  endtask

  task automatic step_exp(input logic v, input logic ok, input logic err,
                          input logic rr, input logic gr, input logic lk,
                          input logic [7:0] we, input string tag);
    exp_t e;
    e.rr  = rr;
    e.gr  = gr;
    e.lk  = lk;
    e.we  = STATS ? we : 8'd0;
    e.tag = tag;
    sb_q.push_back(e);
    tick(v, ok, err);
    sb_check();
  endtask

  function automatic void add_vec(input int cnt, input logic v, input logic ok, input logic err,
                                  input logic rr, input logic gr, input logic lk,
                                  input logic [7:0] we, input string tag);
    vec_t x;
    x.cnt = cnt; x.v = v; x.ok = ok; x.err = err;
    x.rr = rr; x.gr = gr; x.lk = lk; x.we = we; x.tag = tag;
    vecs.push_back(x);
  endfunction

  initial begin
    // ACQUIRE: broken run, then a full run (invalid words neither count nor reset)
    add_vec(63,  1, 1, 0, 0, 0, 0, 0,  "acq_63good");
    add_vec(1,   1, 1, 1, 0, 0, 0, 0,  "acq_err_priority");
    add_vec(31,  1, 1, 0, 0, 0, 0, 0,  "acq_31good");
    add_vec(5,   0, 1, 1, 0, 0, 0, 0,  "acq_invalid");
    add_vec(32,  1, 1, 0, 0, 0, 0, 0,  "acq_63rd_good");
    add_vec(1,   1, 1, 0, 0, 0, 1, 0,  "acq_64th_good_lock");
    // LOCKED: 15 errors per window, wrap-cycle error opens the next window at 1
    add_vec(15,  1, 0, 1, 0, 0, 1, 15, "w1_15err");
    add_vec(240, 1, 1, 0, 0, 0, 1, 15, "w1_fill");
    add_vec(1,   1, 0, 1, 0, 0, 1, 1,  "w1_wrap_err");
    add_vec(14,  1, 0, 1, 0, 0, 1, 15, "w2_14err");
    add_vec(241, 1, 1, 0, 0, 0, 1, 15, "w2_fill");
    add_vec(1,   1, 1, 0, 0, 0, 1, 0,  "w2_wrap_clean");
    add_vec(5,   0, 0, 1, 0, 0, 1, 0,  "w3_invalid_err");
    add_vec(15,  1, 0, 1, 0, 0, 1, 15, "w3_15err");
    add_vec(240, 1, 1, 0, 0, 0, 1, 15, "w3_fill");
    add_vec(1,   1, 1, 0, 0, 0, 1, 0,  "w3_wrap_clean");
    add_vec(15,  1, 0, 1, 0, 0, 1, 15, "w4_15err");
    add_vec(1,   1, 0, 1, 1, 0, 0, 16, "w4_16th_err_relock");
    add_vec(1,   0, 0, 0, 0, 1, 0, 0,  "w4_grace");

    srst = 1'b1;
    repeat (3) tick(0, 0, 0);
    chk("reset.relock_req",   32'(relock_req),   32'd0);
    chk("reset.grace",        32'(grace),        32'd0);
    chk("reset.locked",       32'(locked),       32'd0);
    chk("reset.win_errs",     32'(win_errs),     32'd0);
    chk("reset.relock_count", 32'(relock_count), 32'd0);

    srst = 1'b0;
    step_exp(0, 0, 0, 1, 0, 0, 0, "c1_relock");
    grace_len = 0;
    for (int c = 2; c <= 65; c++) begin
      tick(0, 0, 0);
      if (grace === 1'b1) grace_len++;
      if (relock_req !== 1'b0 || locked !== 1'b0) stray++;
    end
    chk("grace_len", 32'(grace_len), 32'(GRACE));
    chk("rc_after_first", 32'(relock_count), STATS ? 32'd1 : 32'd0);
    step_exp(0, 0, 0, 0, 0, 0, 0, "c66_acquire");

    for (int c = 67; c <= 66 + ACQ_TO - 1; c++) begin
      tick(0, 0, 0);
      if (relock_req !== 1'b0 || grace !== 1'b0 || locked !== 1'b0) stray++;
    end
    step_exp(0, 0, 0, 1, 0, 0, 0, "timeout_relock");
    step_exp(1, 0, 1, 0, 1, 0, 0, "grace2_first");
    chk("rc_after_timeout", 32'(relock_count), STATS ? 32'd2 : 32'd0);
    for (int c = 0; c < GRACE - 1; c++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step_exp(1, 0, 1, 0, 0, 0, 0, "acq2_entry");

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cnt; k++) begin
        if (k == vecs[i].cnt - 1) begin
          step_exp(vecs[i].v, vecs[i].ok, vecs[i].err, vecs[i].rr, vecs[i].gr,
                   vecs[i].lk, vecs[i].we, vecs[i].tag);
        end else begin
          tick(vecs[i].v, vecs[i].ok, vecs[i].err);
          if (relock_req !== 1'b0) stray++;
        end
      end
    end

    // reset mid-GRACE
    repeat (10) tick(1, 0, 1);
    srst = 1'b1;
    step_exp(1, 1, 1, 0, 0, 0, 0, "srst_mid_grace");
    chk("srst_grace.relock_count", 32'(relock_count), 32'd0);
    srst = 1'b0;
    step_exp(0, 0, 0, 1, 0, 0, 0, "rel_after_srst1");
    step_exp(0, 0, 0, 0, 1, 0, 0, "grace_after_srst1");
    chk("rc_after_srst1", 32'(relock_count), STATS ? 32'd1 : 32'd0);
    repeat (GRACE - 1) tick(0, 0, 0);
    step_exp(0, 0, 0, 0, 0, 0, 0, "acq3_entry");
    repeat (GOOD - 1) tick(1, 1, 0);
    step_exp(1, 1, 0, 0, 0, 1, 0, "lock3");

    // reset mid-LOCKED with errors on the inputs
    repeat (4) tick(1, 0, 1);
    step_exp(1, 0, 1, 0, 0, 1, 5, "lock3_5err");
    srst = 1'b1;
    step_exp(1, 0, 1, 0, 0, 0, 0, "srst_mid_locked");
    chk("srst_locked.relock_count", 32'(relock_count), 32'd0);
    srst = 1'b0;
    step_exp(0, 0, 0, 1, 0, 0, 0, "rel_after_srst2");
    step_exp(0, 0, 0, 0, 1, 0, 0, "grace_after_srst2");
    chk("rc_after_srst2", 32'(relock_count), STATS ? 32'd1 : 32'd0);

    chk("no_stray_outputs", 32'(stray), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
